// File: rtl/midi_pkg.sv
// Shared MIDI constants and voice-table request encoding for the event decoder.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF       = 4'h8;
    localparam logic [3:0] NOTE_ON        = 4'h9;
    localparam logic [3:0] POLY_PRESSURE  = 4'hA;
    localparam logic [3:0] CONTROL_CHANGE = 4'hB;
    localparam logic [3:0] PROGRAM_CHANGE = 4'hC;
    localparam logic [3:0] CHAN_PRESSURE  = 4'hD;
    localparam logic [3:0] PITCH_BEND     = 4'hE;

    localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    typedef enum logic [1:0] {
        VREQ_NONE  = 2'd0,
        VREQ_ON    = 2'd1,
        VREQ_OFF   = 2'd2,
        VREQ_CLEAR = 2'd3
    } vreq_e;

    // Program change and channel pressure carry one data byte; all others carry two.
    function automatic logic two_data_bytes(input logic [3:0] msg_type);
        return !(msg_type == PROGRAM_CHANGE || msg_type == CHAN_PRESSURE);
    endfunction

endpackage

// File: rtl/midi_voice_alloc.sv
// Voice slot table: combinational lookup/allocation of a request, table updated on the clock edge.
module midi_voice_alloc
    import midi_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    localparam int IDX_W = $clog2(NUM_VOICES)
) (
    input  logic             clk32,
    input  logic             rst_n,
    input  vreq_e            req_op,
    input  logic [3:0]       req_chan,
    input  logic [6:0]       req_note,
    output logic [IDX_W-1:0] rsp_idx,
    output logic             rsp_hit,
    output logic             rsp_valid
);

    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [3:0]            chan_q [NUM_VOICES];
    logic [3:0]            chan_d [NUM_VOICES];
    logic [6:0]            note_q [NUM_VOICES];
    logic [6:0]            note_d [NUM_VOICES];
    logic [IDX_W-1:0]      steal_ptr_q, steal_ptr_d;

    logic             hit;
    logic             free_found;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] sel_idx;

    // Scan downwards so the lowest matching / lowest free slot wins.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (active_q[i] && chan_q[i] == req_chan && note_q[i] == req_note) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        active_d    = active_q;
        chan_d      = chan_q;
        note_d      = note_q;
        steal_ptr_d = steal_ptr_q;
        sel_idx     = '0;
        rsp_valid   = 1'b0;
        rsp_hit     = hit;
        case (req_op)
            VREQ_ON: begin
                rsp_valid = 1'b1;
                if (hit) begin
                    sel_idx = hit_idx;
                end else if (free_found) begin
                    sel_idx = free_idx;
                end else begin
                    sel_idx     = steal_ptr_q;
                    steal_ptr_d = (steal_ptr_q == IDX_W'(NUM_VOICES - 1)) ? '0
                                                                         : steal_ptr_q + IDX_W'(1);
                end
                active_d[sel_idx] = 1'b1;
                chan_d[sel_idx]   = req_chan;
                note_d[sel_idx]   = req_note;
            end
            VREQ_OFF: begin
                if (hit) begin
                    rsp_valid         = 1'b1;
                    sel_idx           = hit_idx;
                    active_d[hit_idx] = 1'b0;
                end
            end
            VREQ_CLEAR: active_d = '0;
            default: ;
        endcase
        rsp_idx = sel_idx;
    end

    always_ff @(posedge clk32) begin
        if (!rst_n) begin
            active_q    <= '0;
            steal_ptr_q <= '0;
        end else begin
            active_q    <= active_d;
            steal_ptr_q <= steal_ptr_d;
        end
    end

    // Channel/note contents are only meaningful while the slot is active.
    always_ff @(posedge clk32) begin
        chan_q <= chan_d;
        note_q <= note_d;
    end

endmodule

// File: rtl/midi_event_decoder.sv
// MIDI byte-stream parser: running status, channel filter, voice allocation and one-cycle event pulses.
module midi_event_decoder
    import midi_pkg::*;
#(
    parameter int         NUM_VOICES  = 8,
    parameter logic [4:0] CHAN_FILTER = 5'h10
) (
    input  logic       clk32,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       note_pressed,
    output logic       note_released,
    output logic       note_keypress,
    output logic       note_channelpress,
    output logic [6:0] note_interface,
    output logic [6:0] velocity,
    output logic [3:0] channel,
    output logic       c_valid,
    output logic [6:0] c_cmd,
    output logic [7:0] c_byte0,
    output logic [7:0] c_byte1,
    output logic [7:0] c_byte2
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    logic       rs_valid_q, rs_valid_d;
    logic [3:0] rs_type_q, rs_type_d;
    logic [3:0] rs_chan_q, rs_chan_d;
    logic       cnt_q, cnt_d;
    logic [6:0] d1_q, d1_d;

    logic       msg_done;
    logic       chan_ok;
    logic [6:0] msg_d1;
    logic [6:0] msg_d2;
    vreq_e      vreq;

    logic [IDX_W-1:0] v_idx;
    logic             v_hit;
    logic             v_valid;

    logic       pressed_q, pressed_d;
    logic       released_q, released_d;
    logic       keypress_q, keypress_d;
    logic       chanpress_q, chanpress_d;
    logic       c_valid_q, c_valid_d;
    logic [6:0] note_num_q, note_num_d;
    logic [6:0] velocity_q, velocity_d;
    logic [3:0] channel_q, channel_d;
    logic [6:0] c_cmd_q, c_cmd_d;
    logic [7:0] c_byte0_q, c_byte0_d;
    logic [7:0] c_byte1_q, c_byte1_d;
    logic [7:0] c_byte2_q, c_byte2_d;

    assign chan_ok = CHAN_FILTER[4] || (rs_chan_q == CHAN_FILTER[3:0]);
    assign msg_d1  = two_data_bytes(rs_type_q) ? d1_q : rx_data[6:0];
    assign msg_d2  = rx_data[6:0];

    always_comb begin
        rs_valid_d = rs_valid_q;
        rs_type_d  = rs_type_q;
        rs_chan_d  = rs_chan_q;
        cnt_d      = cnt_q;
        d1_d       = d1_q;
        msg_done   = 1'b0;
        if (rx_valid) begin
            if (rx_data[7]) begin
                if (rx_data[7:4] != 4'hF) begin
                    rs_valid_d = 1'b1;
                    rs_type_d  = rx_data[7:4];
                    rs_chan_d  = rx_data[3:0];
                    cnt_d      = 1'b0;
                end else if (!rx_data[3]) begin
                    // System common / sysex: drop running status; realtime (F8-FF) falls through untouched.
                    rs_valid_d = 1'b0;
                    cnt_d      = 1'b0;
                end
            end else if (rs_valid_q) begin
                if (two_data_bytes(rs_type_q) && !cnt_q) begin
                    d1_d  = rx_data[6:0];
                    cnt_d = 1'b1;
                end else begin
                    cnt_d    = 1'b0;
                    msg_done = chan_ok;
                end
            end
        end
    end

    always_comb begin
        vreq = VREQ_NONE;
        if (msg_done) begin
            case (rs_type_q)
                NOTE_ON:  vreq = (msg_d2 != 7'd0) ? VREQ_ON : VREQ_OFF;
                NOTE_OFF: vreq = VREQ_OFF;
                CONTROL_CHANGE: begin
                    if (msg_d1 == CC_ALL_SOUND_OFF || msg_d1 == CC_ALL_NOTES_OFF) begin
                        vreq = VREQ_CLEAR;
                    end
                end
                default: vreq = VREQ_NONE;
            endcase
        end
    end

    midi_voice_alloc #(
        .NUM_VOICES(NUM_VOICES)
    ) u_voice_alloc (
        .clk32    (clk32),
        .rst_n    (rst_n),
        .req_op   (vreq),
        .req_chan (rs_chan_q),
        .req_note (msg_d1),
        .rsp_idx  (v_idx),
        .rsp_hit  (v_hit),
        .rsp_valid(v_valid)
    );

    always_comb begin
        pressed_d   = (vreq == VREQ_ON);
        released_d  = (vreq == VREQ_OFF) && v_valid;
        keypress_d  = msg_done && (rs_type_q == POLY_PRESSURE);
        chanpress_d = msg_done && (rs_type_q == CHAN_PRESSURE);
        c_valid_d   = msg_done && (rs_type_q == CONTROL_CHANGE);
        note_num_d  = note_num_q;
        velocity_d  = velocity_q;
        channel_d   = channel_q;
        c_cmd_d     = c_cmd_q;
        c_byte0_d   = c_byte0_q;
        c_byte1_d   = c_byte1_q;
        c_byte2_d   = c_byte2_q;
        if (pressed_d || released_d) begin
            note_num_d = msg_d1;
            velocity_d = msg_d2;
            channel_d  = rs_chan_q;
            c_byte0_d  = 8'(v_idx);
        end
        if (keypress_d) begin
            note_num_d = msg_d1;
            velocity_d = msg_d2;
            channel_d  = rs_chan_q;
        end
        if (chanpress_d) begin
            velocity_d = msg_d1;
            channel_d  = rs_chan_q;
        end
        if (c_valid_d) begin
            c_cmd_d   = msg_d1;
            c_byte1_d = {1'b0, msg_d2};
            c_byte2_d = {4'h0, rs_chan_q};
        end
    end

    always_ff @(posedge clk32) begin
        if (!rst_n) begin
            rs_valid_q  <= 1'b0;
            rs_type_q   <= 4'h0;
            rs_chan_q   <= 4'h0;
            cnt_q       <= 1'b0;
            d1_q        <= 7'd0;
            pressed_q   <= 1'b0;
            released_q  <= 1'b0;
            keypress_q  <= 1'b0;
            chanpress_q <= 1'b0;
            c_valid_q   <= 1'b0;
            note_num_q  <= 7'd0;
            velocity_q  <= 7'd0;
            channel_q   <= 4'h0;
            c_cmd_q     <= 7'd0;
            c_byte0_q   <= 8'h00;
            c_byte1_q   <= 8'h00;
            c_byte2_q   <= 8'h00;
        end else begin
            rs_valid_q  <= rs_valid_d;
            rs_type_q   <= rs_type_d;
            rs_chan_q   <= rs_chan_d;
            cnt_q       <= cnt_d;
            d1_q        <= d1_d;
            pressed_q   <= pressed_d;
            released_q  <= released_d;
            keypress_q  <= keypress_d;
            chanpress_q <= chanpress_d;
            c_valid_q   <= c_valid_d;
            note_num_q  <= note_num_d;
            velocity_q  <= velocity_d;
            channel_q   <= channel_d;
            c_cmd_q     <= c_cmd_d;
            c_byte0_q   <= c_byte0_d;
            c_byte1_q   <= c_byte1_d;
            c_byte2_q   <= c_byte2_d;
        end
    end

    assign note_pressed      = pressed_q;
    assign note_released     = released_q;
    assign note_keypress     = keypress_q;
    assign note_channelpress = chanpress_q;
    assign c_valid           = c_valid_q;
    assign note_interface    = note_num_q;
    assign velocity          = velocity_q;
    assign channel           = channel_q;
    assign c_cmd             = c_cmd_q;
    assign c_byte0           = c_byte0_q;
    assign c_byte1           = c_byte1_q;
    assign c_byte2           = c_byte2_q;

endmodule

// File: tb/tb_midi_event_decoder.sv
// Directed bench for midi_event_decoder: omni instance plus a channel-3 filtered instance on the same byte stream.
module tb_midi_event_decoder;

    logic       clk32;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;

    logic       a_pressed, a_released, a_keypress, a_chanpress, a_c_valid;
    logic [6:0] a_note, a_vel, a_c_cmd;
    logic [3:0] a_chan;
    logic [7:0] a_cb0, a_cb1, a_cb2;

    logic       b_pressed, b_released, b_keypress, b_chanpress, b_c_valid;
    logic [6:0] b_note, b_vel, b_c_cmd;
    logic [3:0] b_chan;
    logic [7:0] b_cb0, b_cb1, b_cb2;

    logic [4:0] a_pulses, b_pulses;
    assign a_pulses = {a_pressed, a_released, a_keypress, a_chanpress, a_c_valid};
    assign b_pulses = {b_pressed, b_released, b_keypress, b_chanpress, b_c_valid};

    int n_cmp  = 0;
    int n_fail = 0;

    midi_event_decoder dut_a (
        .clk32(clk32), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .note_pressed(a_pressed), .note_released(a_released), .note_keypress(a_keypress),
        .note_channelpress(a_chanpress), .note_interface(a_note), .velocity(a_vel),
        .channel(a_chan), .c_valid(a_c_valid), .c_cmd(a_c_cmd),
        .c_byte0(a_cb0), .c_byte1(a_cb1), .c_byte2(a_cb2)
    );

    midi_event_decoder #(.NUM_VOICES(8), .CHAN_FILTER(5'h03)) dut_b (
        .clk32(clk32), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .note_pressed(b_pressed), .note_released(b_released), .note_keypress(b_keypress),
        .note_channelpress(b_chanpress), .note_interface(b_note), .velocity(b_vel),
        .channel(b_chan), .c_valid(b_c_valid), .c_cmd(b_c_cmd),
        .c_byte0(b_cb0), .c_byte1(b_cb1), .c_byte2(b_cb2)
    );

    initial begin
        clk32 = 1'b0;
        forever #5 clk32 = ~clk32;
    end

    // Called at a falling edge; returns at the next falling edge with the byte's result visible.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk32);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk32);
        rst_n = 1'b1;
        @(negedge clk32);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk32);
        n_cmp++; if (a_pulses !== 5'b0) begin n_fail++; $display("FAIL reset_pulses got=%b want=00000", a_pulses); end
        n_cmp++; if ({a_note, a_vel, a_chan, a_c_cmd} !== 25'd0) begin n_fail++; $display("FAIL reset_data got=%h/%h/%h/%h want=0", a_note, a_vel, a_chan, a_c_cmd); end
        n_cmp++; if ({a_cb0, a_cb1, a_cb2} !== 24'h000000) begin n_fail++; $display("FAIL reset_cbytes got=%h%h%h want=000000", a_cb0, a_cb1, a_cb2); end
        rst_n = 1'b1;
        @(negedge clk32);
        n_cmp++; if (a_pulses !== 5'b0) begin n_fail++; $display("FAIL reset_release_pulses got=%b want=00000", a_pulses); end
    endtask

    task automatic test_note_on();
        do_reset();
        send_byte(8'h90);
        send_byte(8'h3C);
        n_cmp++; if (a_pulses !== 5'b0) begin n_fail++; $display("FAIL noteon_partial got=%b want=00000", a_pulses); end
        send_byte(8'h64);
        n_cmp++; if (a_pulses !== 5'b10000) begin n_fail++; $display("FAIL noteon_pulse got=%b want=10000", a_pulses); end
        n_cmp++; if ({a_note, a_vel, a_chan, a_cb0} !== {7'h3C, 7'h64, 4'h0, 8'h00}) begin
            n_fail++; $display("FAIL noteon_data got=%h %h %h %h want=3c 64 0 00", a_note, a_vel, a_chan, a_cb0);
        end
        @(negedge clk32);
        n_cmp++; if (a_pulses !== 5'b0 || a_note !== 7'h3C) begin n_fail++; $display("FAIL noteon_hold got=%b %h want=00000 3c", a_pulses, a_note); end
    endtask

    task automatic test_running_status();
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        n_cmp++; if (a_pressed !== 1'b1 || a_cb0 !== 8'h00) begin n_fail++; $display("FAIL rs_first got=%b %h want=1 00", a_pressed, a_cb0); end
        send_byte(8'h40); send_byte(8'h50);
        n_cmp++; if (a_pressed !== 1'b1 || a_note !== 7'h40 || a_cb0 !== 8'h01) begin
            n_fail++; $display("FAIL rs_second got=%b %h %h want=1 40 01", a_pressed, a_note, a_cb0);
        end
        send_byte(8'h3C); send_byte(8'h00);
        n_cmp++; if (a_pulses !== 5'b01000 || a_note !== 7'h3C || a_cb0 !== 8'h00) begin
            n_fail++; $display("FAIL rs_release got=%b %h %h want=01000 3c 00", a_pulses, a_note, a_cb0);
        end
    endtask

    task automatic test_steal();
        logic [7:0] exp_idx;
        do_reset();
        send_byte(8'h90);
        for (int k = 0; k < 8; k++) begin
            send_byte(8'h30 + 8'(k)); send_byte(8'h64);
            n_cmp++; if (a_pressed !== 1'b1 || a_cb0 !== 8'(k)) begin n_fail++; $display("FAIL fill_%0d got=%b %h want=1 %h", k, a_pressed, a_cb0, 8'(k)); end
        end
        send_byte(8'h38); send_byte(8'h64);
        n_cmp++; if (a_cb0 !== 8'h00) begin n_fail++; $display("FAIL steal_first got=%h want=00", a_cb0); end
        send_byte(8'h39); send_byte(8'h64);
        n_cmp++; if (a_cb0 !== 8'h01) begin n_fail++; $display("FAIL steal_second got=%h want=01", a_cb0); end
        send_byte(8'h32); send_byte(8'h64);
        n_cmp++; if (a_pressed !== 1'b1 || a_cb0 !== 8'h02) begin n_fail++; $display("FAIL retrigger got=%b %h want=1 02", a_pressed, a_cb0); end
        send_byte(8'h3A); send_byte(8'h64);
        n_cmp++; if (a_cb0 !== 8'h02) begin n_fail++; $display("FAIL steal_after_retrig got=%h want=02", a_cb0); end
        send_byte(8'h39); send_byte(8'h00);
        n_cmp++; if (a_released !== 1'b1 || a_cb0 !== 8'h01) begin n_fail++; $display("FAIL release_slot1 got=%b %h want=1 01", a_released, a_cb0); end
        send_byte(8'h3B); send_byte(8'h64);
        n_cmp++; if (a_cb0 !== 8'h01) begin n_fail++; $display("FAIL reuse_free got=%h want=01", a_cb0); end
        for (int k = 0; k < 8; k++) begin
            exp_idx = 8'((3 + k) % 8);
            send_byte(8'h50 + 8'(k)); send_byte(8'h64);
            n_cmp++; if (a_cb0 !== exp_idx) begin n_fail++; $display("FAIL steal_wrap_%0d got=%h want=%h", k, a_cb0, exp_idx); end
        end
    endtask

    task automatic test_realtime_sysex();
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8);
        n_cmp++; if (a_pulses !== 5'b0) begin n_fail++; $display("FAIL realtime_nopulse got=%b want=00000", a_pulses); end
        send_byte(8'h64);
        n_cmp++; if (a_pressed !== 1'b1 || a_note !== 7'h3C || a_vel !== 7'h64) begin
            n_fail++; $display("FAIL realtime_note got=%b %h %h want=1 3c 64", a_pressed, a_note, a_vel);
        end
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hB1); send_byte(8'h07);
        n_cmp++; if (a_pulses !== 5'b0) begin n_fail++; $display("FAIL abort_nopulse got=%b want=00000", a_pulses); end
        send_byte(8'h7F);
        n_cmp++; if (a_pulses !== 5'b00001 || a_c_cmd !== 7'h07 || a_cb1 !== 8'h7F || a_cb2 !== 8'h01) begin
            n_fail++; $display("FAIL cc_event got=%b %h %h %h want=00001 07 7f 01", a_pulses, a_c_cmd, a_cb1, a_cb2);
        end
        send_byte(8'hF0); send_byte(8'h3C); send_byte(8'h64); send_byte(8'hF7); send_byte(8'h3C); send_byte(8'h64);
        n_cmp++; if (a_pulses !== 5'b0 || a_c_cmd !== 7'h07) begin n_fail++; $display("FAIL sysex_discard got=%b %h want=00000 07", a_pulses, a_c_cmd); end
    endtask

    task automatic test_other_types();
        do_reset();
        send_byte(8'hA2); send_byte(8'h3C); send_byte(8'h20);
        n_cmp++; if (a_pulses !== 5'b00100 || a_note !== 7'h3C || a_vel !== 7'h20 || a_chan !== 4'h2) begin
            n_fail++; $display("FAIL keypress got=%b %h %h %h want=00100 3c 20 2", a_pulses, a_note, a_vel, a_chan);
        end
        send_byte(8'hD5); send_byte(8'h33);
        n_cmp++; if (a_pulses !== 5'b00010 || a_vel !== 7'h33 || a_chan !== 4'h5) begin
            n_fail++; $display("FAIL chanpress got=%b %h %h want=00010 33 5", a_pulses, a_vel, a_chan);
        end
        send_byte(8'h44);
        n_cmp++; if (a_pulses !== 5'b00010 || a_vel !== 7'h44) begin n_fail++; $display("FAIL chanpress_rs got=%b %h want=00010 44", a_pulses, a_vel); end
        send_byte(8'hC0); send_byte(8'h05);
        n_cmp++; if (a_pulses !== 5'b0) begin n_fail++; $display("FAIL progchange got=%b want=00000", a_pulses); end
        send_byte(8'hE0); send_byte(8'h00); send_byte(8'h40);
        n_cmp++; if (a_pulses !== 5'b0 || a_vel !== 7'h44) begin n_fail++; $display("FAIL pitchbend got=%b %h want=00000 44", a_pulses, a_vel); end
    endtask

    task automatic test_filter();
        do_reset();
        send_byte(8'h92); send_byte(8'h3C); send_byte(8'h64);
        n_cmp++; if (b_pulses !== 5'b0) begin n_fail++; $display("FAIL filter_block got=%b want=00000", b_pulses); end
        n_cmp++; if (a_pressed !== 1'b1 || a_chan !== 4'h2) begin n_fail++; $display("FAIL omni_accept got=%b %h want=1 2", a_pressed, a_chan); end
        send_byte(8'h93); send_byte(8'h3C); send_byte(8'h64);
        n_cmp++; if (b_pulses !== 5'b10000 || b_chan !== 4'h3 || b_note !== 7'h3C) begin
            n_fail++; $display("FAIL filter_pass got=%b %h %h want=10000 3 3c", b_pulses, b_chan, b_note);
        end
    endtask

    task automatic test_all_notes_off();
        do_reset();
        send_byte(8'h90);
        send_byte(8'h30); send_byte(8'h64);
        send_byte(8'h31); send_byte(8'h64);
        send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'hB0); send_byte(8'h7B); send_byte(8'h00);
        n_cmp++; if (a_pulses !== 5'b00001 || a_c_cmd !== 7'h7B) begin n_fail++; $display("FAIL allnotesoff got=%b %h want=00001 7b", a_pulses, a_c_cmd); end
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
        n_cmp++; if (a_pulses !== 5'b0) begin n_fail++; $display("FAIL off_after_clear got=%b want=00000", a_pulses); end
        send_byte(8'h90); send_byte(8'h31); send_byte(8'h64);
        n_cmp++; if (a_pressed !== 1'b1 || a_cb0 !== 8'h00) begin n_fail++; $display("FAIL realloc_after_clear got=%b %h want=1 00", a_pressed, a_cb0); end
    endtask

    task automatic test_reset_mid_message();
        send_byte(8'h90); send_byte(8'h3C);
        rst_n = 1'b0;
        @(negedge clk32);
        rst_n = 1'b1;
        @(negedge clk32);
        n_cmp++; if (a_pulses !== 5'b0) begin n_fail++; $display("FAIL after_reset got=%b want=00000", a_pulses); end
        send_byte(8'h64);
        n_cmp++; if (a_pulses !== 5'b0 || a_note !== 7'h00) begin n_fail++; $display("FAIL midmsg_reset got=%b %h want=00000 00", a_pulses, a_note); end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk32);
        test_reset();
        test_note_on();
        test_running_status();
        test_steal();
        test_realtime_sysex();
        test_other_types();
        test_filter();
        test_all_notes_off();
        test_reset_mid_message();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
